// File: rtl/frame_buf_rd_ctrl.sv
// Frame buffer read-side controller: credit-limited read issue, latency-matched
// capture into a small skid FIFO, and a valid/ready pixel stream with frame/line markers.
module frame_buf_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_buf_rd_en,
  input  logic [DATA_WIDTH-1:0] i_buf_data_in,
  output logic [DATA_WIDTH-1:0] o_pix_data,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic                  o_pix_sof,
  output logic                  o_pix_eol,
  output logic                  o_pix_eof,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int TOTAL      = H_PIXELS * V_LINES;
  localparam int RD_W       = $clog2(TOTAL + 1);
  localparam int COL_W      = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W      = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = CNT_W + 1;

  localparam logic [RD_W-1:0]  TOTAL_R   = RD_W'(TOTAL);
  localparam logic [RD_W-1:0]  LAST_R    = RD_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_LINES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RD_W-1:0]       r_reads_issued;
  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  r_frame_done;

  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_start_acc;
  logic [CNT_W-1:0]      w_in_flight;
  logic [OCC_W-1:0]      w_occupancy;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A start landing in the frame_done cycle is dropped even though the FSM is already idle.
  assign w_start_acc = (r_state == S_IDLE) && i_start && !r_frame_done;
  assign w_push      = r_vld[RD_LATENCY-1];
  assign w_pop       = o_pix_valid && i_pix_ready;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_in_flight = w_in_flight + CNT_W'(r_vld[i]);
    end
  end

  // Every word in flight or buffered already owns a FIFO slot, so the FIFO cannot overflow.
  assign w_occupancy = OCC_W'(w_in_flight) + OCC_W'(r_count);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (r_state == S_DRAIN) && w_pop && o_pix_eof;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_issue = (r_reads_issued < TOTAL_R) && (w_occupancy < OCC_LIMIT);
        if (w_issue && (r_reads_issued == LAST_R)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && o_pix_eof) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc) begin
      r_reads_issued <= '0;
    end else if (w_issue) begin
      r_reads_issued <= r_reads_issued + RD_W'(1);
    end
  end

  // Bit k set means a read issued k+1 cycles ago; the top bit marks data on i_buf_data_in now.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_buf_data_in;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_buf_rd_en  = ~w_issue;
  assign o_pix_valid  = (r_count != '0);
  assign o_pix_data   = r_mem[r_rd_ptr];
  assign o_pix_sof    = o_pix_valid && (r_col == '0) && (r_row == '0);
  assign o_pix_eol    = o_pix_valid && (r_col == COL_LAST);
  assign o_pix_eof    = o_pix_eol && (r_row == ROW_LAST);
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_buf_rd_ctrl.sv
// Self-checking bench for frame_buf_rd_ctrl: cycle table for a full-rate frame,
// directed corner sequences, and randomized ready/start against a pixel-index model.
module tb_frame_buf_rd_ctrl;

  localparam int DW    = 32;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 2;
  localparam int TOTAL = H * V;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_pix_ready;
  logic [DW-1:0] i_buf_data_in;
  logic          o_buf_rd_en;
  logic [DW-1:0] o_pix_data;
  logic          o_pix_valid;
  logic          o_pix_sof;
  logic          o_pix_eol;
  logic          o_pix_eof;
  logic          o_busy;
  logic          o_frame_done;

  frame_buf_rd_ctrl #(
    .DATA_WIDTH (DW),
    .H_PIXELS   (H),
    .V_LINES    (V),
    .RD_LATENCY (LAT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .o_buf_rd_en   (o_buf_rd_en),
    .i_buf_data_in (i_buf_data_in),
    .o_pix_data    (o_pix_data),
    .o_pix_valid   (o_pix_valid),
    .i_pix_ready   (i_pix_ready),
    .o_pix_sof     (o_pix_sof),
    .o_pix_eol     (o_pix_eol),
    .o_pix_eof     (o_pix_eof),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit st;
    bit rdy;
    bit rdEn;
    bit valid;
    int data;
    bit sof;
    bit eol;
    bit eof;
    bit busy;
    bit done;
  } vec_t;

  vec_t vecs [14];

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // Reference model: pixel index within the frame and read/accept bookkeeping.
  int            expPix        = 0;
  bit            doneDue       = 1'b0;
  int            issued        = 0;
  int            accepted      = 0;
  int            issuedInFrame = 0;
  int            hsCount       = 0;
  int            doneCount     = 0;
  int            rdLowCount    = 0;
  bit            holdPend      = 1'b0;
  logic [DW-1:0] holdData;
  bit            holdSof;
  bit            holdEol;
  bit            holdEof;

  // Frame buffer model: returns read index + 1 one cycle after a read enable.
  bit pendRead = 1'b0;
  int pendIdx  = 0;
  int fbIdx    = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic scoreboard();
    checkOutput("frame_done", o_frame_done, doneDue);
    if (doneDue) checkOutput("busy_at_done", o_busy, 1'b0);
    if (o_frame_done) doneCount++;
    if (i_reset) begin
      expPix = 0; doneDue = 0; issued = 0; accepted = 0; issuedInFrame = 0; holdPend = 0;
      return;
    end
    doneDue = 1'b0;
    if (holdPend) begin
      checkOutput("hold_valid", o_pix_valid, 1'b1);
      checkOutput("hold_data", o_pix_data, holdData);
      checkOutput("hold_sof", o_pix_sof, holdSof);
      checkOutput("hold_eol", o_pix_eol, holdEol);
      checkOutput("hold_eof", o_pix_eof, holdEof);
    end
    holdPend = 1'b0;
    if (!o_buf_rd_en) begin
      checkOutput("read_credit", DW'((issued - accepted) < DEPTH), 1'b1);
      checkOutput("read_frame_limit", DW'(issuedInFrame < TOTAL), 1'b1);
      checkOutput("read_when_busy", o_busy, 1'b1);
      issued++; issuedInFrame++; rdLowCount++;
    end
    if (o_pix_valid && i_pix_ready) begin
      checkOutput("pix_data", o_pix_data, DW'(expPix + 1));
      checkOutput("pix_sof", o_pix_sof, DW'(expPix == 0));
      checkOutput("pix_eol", o_pix_eol, DW'((expPix % H) == H - 1));
      checkOutput("pix_eof", o_pix_eof, DW'(expPix == TOTAL - 1));
      accepted++; hsCount++; expPix++;
      if (expPix == TOTAL) begin
        expPix = 0; doneDue = 1'b1; issuedInFrame = 0;
      end
    end else if (o_pix_valid) begin
      holdPend = 1'b1;
      holdData = o_pix_data;
      holdSof  = o_pix_sof;
      holdEol  = o_pix_eol;
      holdEof  = o_pix_eof;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit rdy);
    @(negedge i_clk);
    cyc++;
    i_reset     = rst;
    i_start     = st;
    i_pix_ready = rdy;
    i_buf_data_in = pendRead ? DW'(pendIdx + 1) : DW'($urandom);
    if (!o_buf_rd_en) begin
      pendRead = 1'b1; pendIdx = fbIdx; fbIdx++;
    end else begin
      pendRead = 1'b0;
    end
    if (rst || o_frame_done) fbIdx = 0;
    scoreboard();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_en"}, o_buf_rd_en, 1'b1);
    checkOutput({tag, "_valid"}, o_pix_valid, 1'b0);
    checkOutput({tag, "_busy"}, o_busy, 1'b0);
    checkOutput({tag, "_done"}, o_frame_done, 1'b0);
    checkOutput({tag, "_sof"}, o_pix_sof, 1'b0);
    checkOutput({tag, "_eol"}, o_pix_eol, 1'b0);
    checkOutput({tag, "_eof"}, o_pix_eof, 1'b0);
    checkOutput({tag, "_data"}, o_pix_data, '0);
  endtask

  // mode 0: ready held high, 1: alternating, 2: random. startAt injects a stray start.
  task automatic runUntilDone(input int mode, input int budget, input int startAt);
    bit seen = 1'b0;
    bit rdy;
    for (int k = 0; k < budget && !seen; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 2) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(1'b0, k == startAt, rdy);
      if (o_frame_done) seen = 1'b1;
    end
    checkOutput("frame_done_timeout", seen, 1'b1);
  endtask

  initial begin
    int h0;
    int d0;
    int r0;
    bit gotThree;

    i_reset = 1'b1; i_start = 1'b0; i_pix_ready = 1'b0; i_buf_data_in = '0;

    vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 1, 0, 1, 1, 1, 0, 0, 1, 0};
    vecs[4]  = '{0, 1, 0, 1, 2, 0, 0, 0, 1, 0};
    vecs[5]  = '{0, 1, 0, 1, 3, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 1, 4, 0, 1, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 1, 5, 0, 0, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 1, 6, 0, 0, 0, 1, 0};
    vecs[9]  = '{0, 1, 1, 1, 7, 0, 0, 0, 1, 0};
    vecs[10] = '{0, 1, 1, 1, 8, 0, 1, 1, 1, 0};
    vecs[11] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

    $display("[TB] reset values");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkResetValues("rst_hold1");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkResetValues("rst_hold2");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkResetValues("rst_hold3");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkResetValues("rst_after");

    $display("[TB] full-rate frame table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, vecs[i].st, vecs[i].rdy);
      checkOutput("tbl_rd_en", o_buf_rd_en, vecs[i].rdEn);
      checkOutput("tbl_valid", o_pix_valid, vecs[i].valid);
      checkOutput("tbl_busy", o_busy, vecs[i].busy);
      checkOutput("tbl_done", o_frame_done, vecs[i].done);
      if (vecs[i].valid) begin
        checkOutput("tbl_data", o_pix_data, DW'(vecs[i].data));
        checkOutput("tbl_sof", o_pix_sof, vecs[i].sof);
        checkOutput("tbl_eol", o_pix_eol, vecs[i].eol);
        checkOutput("tbl_eof", o_pix_eof, vecs[i].eof);
      end
    end
    runUntilDone(0, 40, -1);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 1'b0);
    h0 = hsCount;
    r0 = rdLowCount;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_reads", DW'(rdLowCount - r0), DW'(DEPTH));
    checkOutput("bp_rd_en_idle", o_buf_rd_en, 1'b1);
    checkOutput("bp_valid", o_pix_valid, 1'b1);
    checkOutput("bp_data", o_pix_data, DW'(1));
    checkOutput("bp_sof", o_pix_sof, 1'b1);
    runUntilDone(0, 40, -1);
    checkOutput("bp_pixels", DW'(hsCount - h0), DW'(TOTAL));

    $display("[TB] toggling ready");
    applyStimulus(1'b0, 1'b0, 1'b1);
    h0 = hsCount;
    applyStimulus(1'b0, 1'b1, 1'b1);
    runUntilDone(1, 60, -1);
    checkOutput("tog_pixels", DW'(hsCount - h0), DW'(TOTAL));

    $display("[TB] start while busy");
    applyStimulus(1'b0, 1'b0, 1'b1);
    h0 = hsCount;
    d0 = doneCount;
    applyStimulus(1'b0, 1'b1, 1'b1);
    runUntilDone(2, 100, 3);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ign_pixels", DW'(hsCount - h0), DW'(TOTAL));
    checkOutput("ign_done_pulses", DW'(doneCount - d0), DW'(1));
    checkOutput("ign_busy_after", o_busy, 1'b0);

    $display("[TB] reset mid-frame");
    h0 = hsCount;
    gotThree = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 30 && !gotThree; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (hsCount - h0 >= 3) gotThree = 1'b1;
    end
    checkOutput("mid_three_accepted", gotThree, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkResetValues("mid_rst");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("mid_no_stale_valid", o_pix_valid, 1'b0);
    h0 = hsCount;
    applyStimulus(1'b0, 1'b1, 1'b1);
    runUntilDone(0, 40, -1);
    checkOutput("mid_new_frame_pixels", DW'(hsCount - h0), DW'(TOTAL));

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      applyStimulus(1'b0, 1'b0, 1'b0);
      h0 = hsCount;
      d0 = doneCount;
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      runUntilDone(2, 200, $urandom_range(0, 12));
      checkOutput("rnd_pixels", DW'(hsCount - h0), DW'(TOTAL));
      checkOutput("rnd_done_pulses", DW'(doneCount - d0), DW'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
